gpio_bus_arbiter: RTL and testbench
===================================

# gpio_bus_arbiter

Two-master bus arbiter and sequencer in front of the memory-mapped GPIO block. It shares the single GPIO address/data/read/write bus between master 0 (LEGv8 core data-memory port) and master 1 (debug/DMA port). Masters are granted round-robin. Each transaction runs as an atomic, cycle-sequenced read, write, bit-set or bit-clear; set and clear are read-modify-write operations that the other master cannot interleave.

## Interface
Parameters:
- `n`, 64, data and address width

Ports:
- `clock`, in, 1, rising-edge clock
- `reset`, in, 1, synchronous, active-high
- `req0` / `req1`, in, 1, transaction request per master; held high until that master's ack
- `op0` / `op1`, in, 2, operation: 00 read, 01 write, 10 set bits, 11 clear bits
- `addr0` / `addr1`, in, n, target GPIO register address (0 OUT, 1 DIR, 2 IN)
- `wdata0` / `wdata1`, in, n, write data, or bit mask for set/clear
- `ack0` / `ack1`, out, 1, one-cycle completion pulse
- `rdata0` / `rdata1`, out, n, read result, valid while ack is high
- `busy`, out, 1, high in any state other than IDLE
- `address`, out, n, shared GPIO bus address
- `data`, inout, n, shared GPIO data bus; this block drives it only in WRITE
- `read`, out, 1, shared bus read strobe
- `write`, out, 1, shared bus write strobe

## Operation
- FSM states: IDLE, READ, WRITE, DONE.
- **IDLE**
  - Sample `req0` and `req1`.
  - If only one is high, grant it.
  - If both are high, grant the master that was not granted last. A `last` pointer resets so that master 0 wins the first tie.
  - On grant, latch op, addr, wdata and master id. Update `last`.
  - Next state is READ for op 00, 10 and 11. Next state is WRITE for op 01.
- **READ**
  - `address` = latched addr, `read` = 1, `data` released.
  - At the clock edge, capture `data` into `rd_q`.
  - Op 00 goes to DONE. Ops 10 and 11 go to WRITE.
- **WRITE**
  - `address` = latched addr, `write` = 1.
  - `data` is driven with:
    - op 01: wdata
    - op 10: rd_q | wdata
    - op 11: rd_q & ~wdata
  - Next state is DONE.
- **DONE**
  - The granted master's ack is 1. Its rdata is rd_q for ops 00/10/11 (the pre-modify value) and 0 for op 01.
  - Next state is IDLE.
- The non-granted master's ack stays 0 and its rdata holds its previous value.
- Bus outputs are registered decodes of the state and are glitch-free. In IDLE and DONE: `read` = 0, `write` = 0, `address` = 0, `data` = z.
- A request that rises while the FSM is busy waits. It is arbitrated at the next IDLE.
- Reads of unmapped addresses return whatever the bus presents. The result is undefined, with no error flag.
- Writes to IN (address 2) are issued on the bus and have no effect there.

## Timing
- Reset values: state IDLE, `last` = 1 (so master 0 wins the first tie), `ack0` = `ack1` = 0, `rdata0` = `rdata1` = 0, `busy` = 0, `read` = `write` = 0, `address` = 0, `data` = z, `rd_q` = 0.
- Latency is counted from the IDLE cycle in which req is sampled high to the ack cycle:
  - read: 2 cycles
  - write: 2 cycles
  - set/clear: 3 cycles
- After DONE, the FSM spends 1 IDLE cycle before the next grant. Throughput is one read/write per 3 cycles and one set/clear per 4 cycles.
- Handshake:
  - A master holds req, op, addr and wdata stable from req rise until it sees ack.
  - It deasserts req at the edge ending DONE.
  - If req is still high in IDLE, it is treated as a new transaction.
- The GPIO register update lands at the edge ending WRITE. A read issued in the following transaction observes the new value.
- Reset asserted in any state returns the FSM to IDLE at that edge:
  - The bus is released and no ack is issued.
  - A write that was in WRITE during the reset cycle is overridden, because the GPIO shares `reset` and clears to 0 at the same edge.

## Test plan
- **Read after reset.** Reset, then `req0`=1, op 00, addr 0. Required: `read`=1 for 1 cycle at address 0, `ack0` 2 cycles after the IDLE sample, `rdata0` = 0.
- **Write then read back.**
  - `req1` op 01, addr 1, wdata 0xFF. Required: `write` pulses once with `data` = 0xFF, `ack1` after 2 cycles.
  - Follow with a read of addr 1. Required: 0xFF.
- **Atomic set/clear.**
  - OUT = 0x0F. Set with mask 0x30. Required: bus writes 0x3F, `rdata` = 0x0F, ack after 3 cycles.
  - Then clear with mask 0x05. Required: OUT = 0x3A.
- **Simultaneous requests.** `req0` and `req1` rise in the same cycle, both repeatedly. Required: grants alternate 0, 1, 0, 1; neither ack overlaps the other; the loser's req stays pending without loss.
- **No interleave during RMW.** `req1` rises during master 0's READ of a set op. Required: master 0 completes READ and WRITE first; master 1 is granted at the next IDLE.
- **Reset mid-RMW.** Reset asserted in the WRITE state. Required: IDLE next cycle, `ack0` never pulses, bus released, OUT = 0.

Source files
------------

// File: rtl/gpio_bus_arbiter.sv
// Round-robin two-master arbiter that sequences atomic read, write, set-bits and
// clear-bits transactions onto the shared GPIO address/data bus.
module gpio_bus_arbiter #(
   parameter int n = 64
) (
   input  logic         clock,
   input  logic         reset,
   input  logic         req0,
   input  logic         req1,
   input  logic [1:0]   op0,
   input  logic [1:0]   op1,
   input  logic [n-1:0] addr0,
   input  logic [n-1:0] addr1,
   input  logic [n-1:0] wdata0,
   input  logic [n-1:0] wdata1,
   output logic         ack0,
   output logic         ack1,
   output logic [n-1:0] rdata0,
   output logic [n-1:0] rdata1,
   output logic         busy,
   output logic [n-1:0] address,
   inout  wire  [n-1:0] data,
   output logic         read,
   output logic         write
);

   localparam logic [1:0] StIdle  = 2'd0;
   localparam logic [1:0] StRead  = 2'd1;
   localparam logic [1:0] StWrite = 2'd2;
   localparam logic [1:0] StDone  = 2'd3;

   localparam logic [1:0] OpRead  = 2'b00;
   localparam logic [1:0] OpWrite = 2'b01;
   localparam logic [1:0] OpSet   = 2'b10;

   logic [1:0]   state_q, state_d;
   logic         last_q, last_d;
   logic [1:0]   op_q;
   logic [n-1:0] addr_q, wdata_q, rd_q, rd_d, wr_data_q, wr_data_d, result;
   logic         id_q;
   logic         gnt_id;
   logic [1:0]   gnt_op;
   logic [n-1:0] gnt_addr, gnt_wdata;

   always_comb begin
      // On a tie, grant whichever master did not win the previous arbitration.
      gnt_id    = req1 && (!req0 || !last_q);
      gnt_op    = gnt_id ? op1 : op0;
      gnt_addr  = gnt_id ? addr1 : addr0;
      gnt_wdata = gnt_id ? wdata1 : wdata0;

      state_d = state_q;
      last_d  = last_q;
      case (state_q)
         StIdle: begin
            if (req0 || req1) begin
               state_d = (gnt_op == OpWrite) ? StWrite : StRead;
               last_d  = gnt_id;
            end
         end
         StRead:  state_d = (op_q == OpRead) ? StDone : StWrite;
         StWrite: state_d = StDone;
         default: state_d = StIdle;
      endcase

      rd_d = (state_q == StRead) ? data : rd_q;

      if (state_q == StIdle) begin
         wr_data_d = gnt_wdata;
      end else if (op_q == OpSet) begin
         wr_data_d = rd_d | wdata_q;
      end else begin
         wr_data_d = rd_d & ~wdata_q;
      end

      result = (op_q == OpWrite) ? '0 : rd_d;
   end

   // Bus strobes and address are registered from the next state so they are glitch-free.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q   <= StIdle;
         last_q    <= 1'b1;
         op_q      <= OpRead;
         addr_q    <= '0;
         wdata_q   <= '0;
         id_q      <= 1'b0;
         rd_q      <= '0;
         wr_data_q <= '0;
         address   <= '0;
         read      <= 1'b0;
         write     <= 1'b0;
         busy      <= 1'b0;
         ack0      <= 1'b0;
         ack1      <= 1'b0;
         rdata0    <= '0;
         rdata1    <= '0;
      end else begin
         state_q <= state_d;
         last_q  <= last_d;
         rd_q    <= rd_d;
         if (state_q == StIdle && (req0 || req1)) begin
            op_q    <= gnt_op;
            addr_q  <= gnt_addr;
            wdata_q <= gnt_wdata;
            id_q    <= gnt_id;
         end
         if (state_d == StWrite) begin
            wr_data_q <= wr_data_d;
         end
         if (state_d == StRead || state_d == StWrite) begin
            address <= (state_q == StIdle) ? gnt_addr : addr_q;
         end else begin
            address <= '0;
         end
         read  <= (state_d == StRead);
         write <= (state_d == StWrite);
         busy  <= (state_d != StIdle);
         ack0  <= (state_d == StDone) && !id_q;
         ack1  <= (state_d == StDone) && id_q;
         if (state_d == StDone && !id_q) begin
            rdata0 <= result;
         end
         if (state_d == StDone && id_q) begin
            rdata1 <= result;
         end
      end
   end

   assign data = write ? wr_data_q : {n{1'bz}};

endmodule

// File: tb/tb_gpio_bus_arbiter.sv
// Scoreboard bench for gpio_bus_arbiter with a small GPIO register model on the shared bus.
module tb_gpio_bus_arbiter;

   localparam int N = 64;
   localparam logic [N-1:0] InVal = 64'h1234;

   logic           clock = 1'b0;
   logic           reset = 1'b1;
   logic [1:0]     req_v;
   logic [1:0]     op_v   [2];
   logic [N-1:0]   addr_v [2];
   logic [N-1:0]   wd_v   [2];
   logic           ack0, ack1, busy, read, write;
   logic [N-1:0]   rdata0, rdata1, address;
   wire  [N-1:0]   data;
   logic           probe_en;
   logic [N-1:0]   probe_val;
   logic [N-1:0]   gpio_out, gpio_dir, gpio_rd;

   typedef struct { logic [N-1:0] rd; int lat; } ack_t;
   typedef struct { bit wr; logic [N-1:0] a; logic [N-1:0] d; } bus_t;

   ack_t exp_q0[$];
   ack_t exp_q1[$];
   bus_t bus_q[$];
   int   ack_log[$];
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   int   issue_cyc[2];

   gpio_bus_arbiter #(.n(N)) dut (
      .clock  (clock),
      .reset  (reset),
      .req0   (req_v[0]),
      .req1   (req_v[1]),
      .op0    (op_v[0]),
      .op1    (op_v[1]),
      .addr0  (addr_v[0]),
      .addr1  (addr_v[1]),
      .wdata0 (wd_v[0]),
      .wdata1 (wd_v[1]),
      .ack0   (ack0),
      .ack1   (ack1),
      .rdata0 (rdata0),
      .rdata1 (rdata1),
      .busy   (busy),
      .address(address),
      .data   (data),
      .read   (read),
      .write  (write)
   );

   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;

   // GPIO register model sharing the bus reset.
   always @(posedge clock) begin
      if (reset) begin
         gpio_out <= '0;
         gpio_dir <= '0;
      end else if (write) begin
         if (address == 0) gpio_out <= data;
         else if (address == 1) gpio_dir <= data;
      end
   end

   always_comb begin
      gpio_rd = 64'hDEAD;
      if (address == 0) gpio_rd = gpio_out;
      else if (address == 1) gpio_rd = gpio_dir;
      else if (address == 2) gpio_rd = InVal;
   end

   assign data = read ? gpio_rd : (probe_en ? probe_val : {N{1'bz}});

   task automatic chk(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, required %h", name, act, exp);
      end
   endtask

   task automatic pop_ack(input int m);
      ack_t e;
      logic [N-1:0] act;
      act = (m == 0) ? rdata0 : rdata1;
      ack_log.push_back(m);
      if ((m == 0 && exp_q0.size() == 0) || (m == 1 && exp_q1.size() == 0)) begin
         checks++;
         errors++;
         $display("FAIL unexpected_ack%0d: got ack with nothing pending, required no ack", m);
      end else begin
         if (m == 0) e = exp_q0.pop_front();
         else e = exp_q1.pop_front();
         chk($sformatf("rdata%0d", m), act, e.rd);
         if (e.lat != 0) chk($sformatf("latency%0d", m), 64'(cyc - issue_cyc[m]), 64'(e.lat));
      end
   endtask

   task automatic pop_bus();
      bus_t e;
      if (bus_q.size() == 0) begin
         checks++;
         errors++;
         $display("FAIL unexpected_bus: got read=%b write=%b addr=%h, required idle bus",
                  read, write, address);
      end else begin
         e = bus_q.pop_front();
         chk("bus_kind_write", {63'd0, write}, {63'd0, e.wr});
         chk("bus_addr", address, e.a);
         if (e.wr) chk("bus_wdata", data, e.d);
      end
   endtask

   // Monitor: pops expectations whenever the DUT presents an ack or a bus strobe.
   always @(negedge clock) begin
      if (ack0 && ack1) begin
         checks++;
         errors++;
         $display("FAIL ack_overlap: got ack0=1 ack1=1, required at most one");
      end
      if (ack0) pop_ack(0);
      if (ack1) pop_ack(1);
      if (read || write) pop_bus();
   end

   task automatic bus_rd(input logic [N-1:0] a);
      bus_q.push_back('{wr: 1'b0, a: a, d: '0});
   endtask

   task automatic bus_wr(input logic [N-1:0] a, input logic [N-1:0] d);
      bus_q.push_back('{wr: 1'b1, a: a, d: d});
   endtask

   // Called at posedge+1; returns at posedge+1 of the edge ending DONE with req dropped.
   task automatic txn(input int m, input logic [1:0] o, input logic [N-1:0] a,
                      input logic [N-1:0] w, input logic [N-1:0] exp_rd, input int exp_lat);
      bit got;
      if (m == 0) exp_q0.push_back('{rd: exp_rd, lat: exp_lat});
      else exp_q1.push_back('{rd: exp_rd, lat: exp_lat});
      op_v[m]      = o;
      addr_v[m]    = a;
      wd_v[m]      = w;
      req_v[m]     = 1'b1;
      issue_cyc[m] = cyc;
      got = 1'b0;
      for (int i = 0; i < 50 && !got; i++) begin
         @(negedge clock);
         if ((m == 0 && ack0) || (m == 1 && ack1)) got = 1'b1;
      end
      if (!got) begin
         checks++;
         errors++;
         $display("FAIL ack_timeout%0d: got no ack in 50 cycles, required ack", m);
      end
      @(posedge clock);
      #1;
      req_v[m] = 1'b0;
   endtask

   task automatic probe_check(input string name, input logic [N-1:0] pattern);
      probe_val = pattern;
      probe_en  = 1'b1;
      #1;
      chk(name, data, pattern);
      probe_en  = 1'b0;
   endtask

   initial begin
      bit seen;
      int acks;
      req_v     = '0;
      op_v[0]   = '0;
      op_v[1]   = '0;
      addr_v[0] = '0;
      addr_v[1] = '0;
      wd_v[0]   = '0;
      wd_v[1]   = '0;
      probe_en  = 1'b0;
      probe_val = '0;

      repeat (3) @(posedge clock);
      @(negedge clock);
      chk("reset_ack0", {63'd0, ack0}, '0);
      chk("reset_ack1", {63'd0, ack1}, '0);
      chk("reset_rdata0", rdata0, '0);
      chk("reset_rdata1", rdata1, '0);
      chk("reset_busy", {63'd0, busy}, '0);
      chk("reset_read", {63'd0, read}, '0);
      chk("reset_write", {63'd0, write}, '0);
      chk("reset_address", address, '0);
      probe_check("reset_data_released", 64'hC0);
      @(posedge clock);
      #1;
      reset = 1'b0;

      bus_rd(0);
      txn(0, 2'b00, 0, 0, 64'h0, 2);
      bus_wr(1, 64'hFF);
      txn(1, 2'b01, 1, 64'hFF, 64'h0, 2);
      bus_rd(1);
      txn(0, 2'b00, 1, 0, 64'hFF, 2);
      bus_wr(0, 64'h0F);
      txn(0, 2'b01, 0, 64'h0F, 64'h0, 2);
      bus_rd(0);
      bus_wr(0, 64'h3F);
      txn(1, 2'b10, 0, 64'h30, 64'h0F, 3);
      bus_rd(0);
      bus_wr(0, 64'h3A);
      txn(0, 2'b11, 0, 64'h05, 64'h3F, 3);
      probe_check("idle_data_released", 64'hC0);
      bus_rd(0);
      txn(1, 2'b00, 0, 0, 64'h3A, 2);

      // Both masters request together, twice each.
      ack_log.delete();
      bus_wr(1, 64'hA5);
      bus_wr(2, 64'h99);
      bus_rd(1);
      bus_rd(2);
      fork
         begin
            txn(0, 2'b01, 1, 64'hA5, 64'h0, 0);
            txn(0, 2'b00, 1, 0, 64'hA5, 0);
         end
         begin
            txn(1, 2'b01, 2, 64'h99, 64'h0, 0);
            txn(1, 2'b00, 2, 0, InVal, 0);
         end
      join
      chk("tie_ack_count", 64'(ack_log.size()), 64'd4);
      for (int i = 0; i < 4; i++) begin
         if (ack_log.size() > i) chk($sformatf("tie_grant_%0d", i), 64'(ack_log[i]), 64'(i % 2));
      end

      // Master 1 requests while master 0's set is in READ.
      ack_log.delete();
      bus_rd(0);
      bus_wr(0, 64'h7A);
      bus_rd(0);
      fork
         txn(0, 2'b10, 0, 64'h40, 64'h3A, 3);
         begin
            @(posedge clock);
            #1;
            txn(1, 2'b00, 0, 0, 64'h7A, 0);
         end
      join
      chk("rmw_ack_count", 64'(ack_log.size()), 64'd2);
      if (ack_log.size() == 2) begin
         chk("rmw_first_grant", 64'(ack_log[0]), 64'd0);
         chk("rmw_second_grant", 64'(ack_log[1]), 64'd1);
      end

      // Reset while master 0's set is in WRITE.
      bus_rd(0);
      bus_wr(0, 64'h7B);
      op_v[0]   = 2'b10;
      addr_v[0] = 0;
      wd_v[0]   = 64'h01;
      req_v[0]  = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 10 && !seen; i++) begin
         @(negedge clock);
         if (write) seen = 1'b1;
      end
      chk("rmw_reached_write", {63'd0, seen}, 64'd1);
      reset = 1'b1;
      @(posedge clock);
      #1;
      req_v[0] = 1'b0;
      reset    = 1'b0;
      chk("midreset_busy", {63'd0, busy}, '0);
      chk("midreset_write", {63'd0, write}, '0);
      chk("midreset_read", {63'd0, read}, '0);
      chk("midreset_address", address, '0);
      probe_check("midreset_data_released", 64'h3C);
      acks = 0;
      repeat (4) begin
         @(negedge clock);
         if (ack0) acks++;
      end
      chk("midreset_no_ack0", 64'(acks), 64'd0);
      @(posedge clock);
      #1;
      bus_rd(0);
      txn(1, 2'b00, 0, 0, 64'h0, 2);

      chk("exp_q0_drained", 64'(exp_q0.size()), 64'd0);
      chk("exp_q1_drained", 64'(exp_q1.size()), 64'd0);
      chk("bus_q_drained", 64'(bus_q.size()), 64'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation still running, required completion");
      $fatal(1, "watchdog expired");
   end

endmodule
